// File: rtl/key_event_gen.sv
// key_event_gen: held-key levels to press/auto-repeat events on a valid/ready port; define KEY_AUTOREPEAT_EN to enable auto-repeat
module key_event_gen #(
    parameter int DELAY_CYC  = 50_000_000,
    parameter int REPEAT_CYC = 10_000_000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    input  logic       enter,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [2:0] evt_code,
    output logic       evt_rpt,
    output logic       evt_drop
);
    typedef enum logic [1:0] {IDLE, HOLD, DELAY, REPEAT} state_t;

    state_t     state, state_n;
    logic [4:0] key_s, key_q, press;
    logic [2:0] trk, trk_n, new_code, emit_code;
    logic       held, emit, emit_rpt;

    if (DELAY_CYC < 2 || REPEAT_CYC < 2) begin : g_param_check
        $error("key_event_gen: DELAY_CYC and REPEAT_CYC must be >= 2");
    end

`ifdef KEY_AUTOREPEAT_EN
    localparam int CW = $clog2(DELAY_CYC > REPEAT_CYC ? DELAY_CYC : REPEAT_CYC) + 1;
    localparam logic [CW-1:0] D_LAST = CW'(DELAY_CYC - 1);
    localparam logic [CW-1:0] R_LAST = CW'(REPEAT_CYC - 1);
    logic [CW-1:0] cnt, cnt_n;
    logic          cnt_hit;
    assign cnt_hit = (state == DELAY && cnt == D_LAST) || (state == REPEAT && cnt == R_LAST);
`endif

    // key bits are ordered by event code minus one: up, down, left, right, enter
    assign press    = key_s & ~key_q;
    assign new_code = press[4] ? 3'd5 : press[0] ? 3'd1 : press[1] ? 3'd2 :
                      press[2] ? 3'd3 : press[3] ? 3'd4 : 3'd0;
    assign held     = key_s[trk - 3'd1];

    // register the key levels, then delay once more for rising-edge detection
    always_ff @(posedge clk) begin
        if (!rstn) begin
            key_s <= '0;
            key_q <= '0;
        end else begin
            key_s <= {enter, right, left, down, up};
            key_q <= key_s;
        end
    end

    // FSM state, tracked key and repeat counter
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            trk   <= '0;
`ifdef KEY_AUTOREPEAT_EN
            cnt   <= '0;
`endif
        end else begin
            state <= state_n;
            trk   <= trk_n;
`ifdef KEY_AUTOREPEAT_EN
            cnt   <= cnt_n;
`endif
        end
    end

    // a fresh press always retracks; otherwise release returns to IDLE before any repeat can fire
    always_comb begin
        state_n = state;
        trk_n   = trk;
`ifdef KEY_AUTOREPEAT_EN
        cnt_n   = cnt + 1'b1;
        if (new_code != 3'd0) begin
            state_n = (new_code == 3'd5) ? HOLD : DELAY;
            trk_n   = new_code;
            cnt_n   = '0;
        end else if (state != IDLE && !held) begin
            state_n = IDLE;
        end else if (cnt_hit) begin
            state_n = REPEAT;
            cnt_n   = '0;
        end
`else
        if (new_code != 3'd0) begin
            state_n = HOLD;
            trk_n   = new_code;
        end else if (state == HOLD && !held) begin
            state_n = IDLE;
        end
`endif
    end

    // event generated this cycle: a fresh press, or a repeat of the tracked key when its timer expires
    always_comb begin
`ifdef KEY_AUTOREPEAT_EN
        emit_rpt  = new_code == 3'd0 && held && cnt_hit;
`else
        emit_rpt  = 1'b0;
`endif
        emit      = new_code != 3'd0 || emit_rpt;
        emit_code = emit_rpt ? trk : new_code;
    end

    // output holding register: load when free or being accepted, otherwise drop the new event
    always_ff @(posedge clk) begin
        if (!rstn) begin
            evt_valid <= 1'b0;
            evt_code  <= '0;
            evt_rpt   <= 1'b0;
            evt_drop  <= 1'b0;
        end else begin
            evt_drop <= emit && evt_valid && !evt_ready;
            if (emit && (!evt_valid || evt_ready)) begin
                evt_valid <= 1'b1;
                evt_code  <= emit_code;
                evt_rpt   <= emit_rpt;
            end else if (evt_ready) begin
                evt_valid <= 1'b0;
                evt_code  <= '0;
                evt_rpt   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_key_event_gen.sv
// tb_key_event_gen: directed vector table plus multi-cycle hold sequences for key_event_gen (DELAY_CYC=10, REPEAT_CYC=4)
module tb_key_event_gen;
    typedef struct {
        logic       rstn;
        logic [4:0] keys;
        logic       rdy;
        logic       v;
        logic [2:0] c;
        logic       r;
        logic       d;
    } vec_t;

    logic       clk   = 1'b0;
    logic       rstn  = 1'b0;
    logic       ready = 1'b1;
    logic [4:0] keys  = '0;
    logic       evt_valid, evt_rpt, evt_drop;
    logic [2:0] evt_code;
    int         n_vec  = 0;
    int         n_fail = 0;
    vec_t       tbl[$];

    key_event_gen #(.DELAY_CYC(10), .REPEAT_CYC(4)) dut (
        .clk(clk), .rstn(rstn),
        .up(keys[0]), .down(keys[1]), .left(keys[2]), .right(keys[3]), .enter(keys[4]),
        .evt_valid(evt_valid), .evt_ready(ready), .evt_code(evt_code),
        .evt_rpt(evt_rpt), .evt_drop(evt_drop)
    );

    always #5 clk = ~clk;

    // keys = {enter, right, left, down, up}; inputs change at negedge, outputs checked 1 ns after posedge
    task automatic step(input logic r_n, input logic [4:0] k, input logic rd,
                        input logic ev, input logic [2:0] ec, input logic er, input logic ed,
                        input string name, input int idx);
        @(negedge clk);
        rstn  = r_n;
        keys  = k;
        ready = rd;
        @(posedge clk);
        #1;
        n_vec++;
        if ({evt_valid, evt_code, evt_rpt, evt_drop} !== {ev, ec, er, ed}) begin
            n_fail++;
            $display("FAIL %s[%0d]: got valid=%b code=%0d rpt=%b drop=%b, want valid=%b code=%0d rpt=%b drop=%b",
                     name, idx, evt_valid, evt_code, evt_rpt, evt_drop, ev, ec, er, ed);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, "idle", i);
    endtask

    initial begin
        bit e, rp;
        logic [2:0] c;
        //                rstn  keys       rdy   v     c     r     d
        tbl.push_back('{1'b0, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 5'b00001, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b00001, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b00001, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b10101, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b10101, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b10101, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b10001, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b10101, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b10101, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b00010, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b00010, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b01010, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b01010, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 5'b01010, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b01010, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b00001, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b00001, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b00011, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b00011, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b00001, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b00001, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 5'b00001, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b00001, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b00001, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b01100, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b01100, 1'b1, 1'b1, 3'd3, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b00011, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b00011, 1'b1, 1'b1, 3'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0});

        foreach (tbl[i])
            step(tbl[i].rstn, tbl[i].keys, tbl[i].rdy, tbl[i].v, tbl[i].c, tbl[i].r, tbl[i].d, "table", i);
        idle(2);

        // up held 30 cycles: press at 1, repeats at 11,15,19,23,27; the repeat due at 31 is cancelled by release
        for (int j = 0; j < 40; j++) begin
`ifdef KEY_AUTOREPEAT_EN
            e = j == 1 || (j >= 11 && j <= 27 && (j - 11) % 4 == 0);
`else
            e = j == 1;
`endif
            step(1'b1, j < 30 ? 5'b00001 : 5'b00000, 1'b1, e, e ? 3'd1 : 3'd0, e && j != 1, 1'b0, "hold_up", j);
        end
        idle(2);

        // enter held 40 cycles: exactly one press event, never repeats
        for (int j = 0; j < 45; j++) begin
            e = j == 1;
            step(1'b1, j < 40 ? 5'b10000 : 5'b00000, 1'b1, e, e ? 3'd5 : 3'd0, 1'b0, 1'b0, "hold_enter", j);
        end
        idle(2);

        // left held, right pressed at 5 and released at 25; left stays silent until re-pressed at 37
        for (int j = 0; j < 45; j++) begin
`ifdef KEY_AUTOREPEAT_EN
            e  = j == 1 || j == 6 || j == 16 || j == 20 || j == 24 || j == 38;
            rp = j == 16 || j == 20 || j == 24;
`else
            e  = j == 1 || j == 6 || j == 38;
            rp = 1'b0;
`endif
            c = !e ? 3'd0 : (j == 1 || j == 38) ? 3'd3 : 3'd4;
            step(1'b1, {1'b0, j >= 5 && j < 25, j < 35 || (j >= 37 && j < 40), 2'b00}, 1'b1,
                 e, c, rp, 1'b0, "left_right", j);
        end
        idle(2);

        // stalled consumer with down held: repeats are dropped, then a repeat is loaded on the accepting edge
        for (int j = 0; j < 23; j++) begin
`ifdef KEY_AUTOREPEAT_EN
            e  = j >= 1 && j <= 19;
            rp = j == 19;
            step(1'b1, j < 20 ? 5'b00010 : 5'b00000, j >= 19, e, e ? 3'd2 : 3'd0, rp,
                 j == 11 || j == 15, "stall_down", j);
`else
            e = j >= 1 && j <= 18;
            step(1'b1, j < 20 ? 5'b00010 : 5'b00000, j >= 19, e, e ? 3'd2 : 3'd0, 1'b0, 1'b0, "stall_down", j);
`endif
        end
        idle(2);

        // reset for one cycle while right is held in REPEAT: fresh press afterwards, delay restarts
        for (int j = 0; j < 32; j++) begin
`ifdef KEY_AUTOREPEAT_EN
            e  = j == 1 || j == 11 || j == 15 || j == 25;
            rp = j == 11 || j == 25;
`else
            e  = j == 1 || j == 15;
            rp = 1'b0;
`endif
            step(j != 13, j < 27 ? 5'b01000 : 5'b00000, 1'b1, e, e ? 3'd4 : 3'd0, rp, 1'b0, "reset_right", j);
        end
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
